butterfly_pipe: RTL and testbench

BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

---
 rtl/butterfly_pipe_if.sv | 30 +++
 rtl/butterfly_pipe.sv | 187 ++++++++++++++++++
 tb/tb_butterfly_pipe.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/butterfly_pipe_if.sv
// Signal bundle for butterfly_pipe: operands, twiddle, metadata, results and overflow control.
// Handshake: x_nd qualifies xa/xb/w/scale/m_in on the same clk edge; y_nd qualifies ya/yb/m_out; no back-pressure exists.
interface butterfly_pipe_if #(
    parameter int DWIDTH = 16,
    parameter int TWIDTH = 16,
    parameter int MWIDTH = 1
) ();
    logic [MWIDTH-1:0]   m_in;
    logic [MWIDTH-1:0]   m_out;
    logic [2*TWIDTH-1:0] w;
    logic [2*DWIDTH-1:0] xa;
    logic [2*DWIDTH-1:0] xb;
    logic                x_nd;
    logic                scale;
    logic [2*DWIDTH-1:0] ya;
    logic [2*DWIDTH-1:0] yb;
    logic                y_nd;
    logic                ovf;
    logic                ovf_clr;

    modport master (
        output m_in, w, xa, xb, x_nd, scale, ovf_clr,
        input  m_out, ya, yb, y_nd, ovf
    );

    modport slave (
        input  m_in, w, xa, xb, x_nd, scale, ovf_clr,
        output m_out, ya, yb, y_nd, ovf
    );
endinterface

// File: rtl/butterfly_pipe.sv
// Pipelined radix-2 butterfly: ya = xa + w*xb, yb = xa - w*xb, latency MULT_STAGES+2.
// Define BUTTERFLY_PIPE_SAT_EN to clamp overflowed components instead of wrapping them.
module butterfly_pipe #(
    parameter int DWIDTH      = 16,
    parameter int TWIDTH      = 16,
    parameter int MWIDTH      = 1,
    parameter int MULT_STAGES = 2
) (
    input logic           clk,
    input logic           rst_n,
    butterfly_pipe_if.slave bus
);
    localparam int PW = DWIDTH + TWIDTH + 1;
    localparam int SW = DWIDTH + 2;
    localparam int L  = MULT_STAGES - 1;
    localparam logic signed [SW-1:0] MAXV = {3'b000, {(DWIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {3'b111, {(DWIDTH-1){1'b0}}};

    // Input register stage
    logic signed [DWIDTH-1:0] r_xa_re, r_xa_im, r_xb_re, r_xb_im;
    logic signed [TWIDTH-1:0] r_w_re, r_w_im;
    logic                     r_in_scale;
    logic                     r_in_vld;
    logic [MWIDTH-1:0]        r_in_m;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_vld <= 1'b0;
        end else begin
            r_in_vld <= bus.x_nd;
        end
    end

    always_ff @(posedge clk) begin
        r_xa_re    <= bus.xa[2*DWIDTH-1:DWIDTH];
        r_xa_im    <= bus.xa[DWIDTH-1:0];
        r_xb_re    <= bus.xb[2*DWIDTH-1:DWIDTH];
        r_xb_im    <= bus.xb[DWIDTH-1:0];
        r_w_re     <= bus.w[2*TWIDTH-1:TWIDTH];
        r_w_im     <= bus.w[TWIDTH-1:0];
        r_in_scale <= bus.scale;
        r_in_m     <= bus.m_in;
    end

    // Full-precision complex product; after the Q1.(TWIDTH-1) shift it needs only DWIDTH+2 bits.
    logic signed [PW-1:0] w_rr, w_ii, w_ri, w_ir, w_pr_full, w_pi_full;
    logic signed [SW-1:0] w_pr, w_pi;

    assign w_rr      = PW'(r_xb_re) * PW'(r_w_re);
    assign w_ii      = PW'(r_xb_im) * PW'(r_w_im);
    assign w_ri      = PW'(r_xb_re) * PW'(r_w_im);
    assign w_ir      = PW'(r_xb_im) * PW'(r_w_re);
    assign w_pr_full = w_rr - w_ii;
    assign w_pi_full = w_ri + w_ir;
    assign w_pr      = SW'(w_pr_full >>> (TWIDTH-1));
    assign w_pi      = SW'(w_pi_full >>> (TWIDTH-1));

    // Multiplier register chain with xa, scale and metadata travelling alongside
    logic signed [SW-1:0]     r_pr_d    [MULT_STAGES];
    logic signed [SW-1:0]     r_pi_d    [MULT_STAGES];
    logic signed [DWIDTH-1:0] r_xa_re_d [MULT_STAGES];
    logic signed [DWIDTH-1:0] r_xa_im_d [MULT_STAGES];
    logic                     r_scale_d [MULT_STAGES];
    logic [MWIDTH-1:0]        r_m_d     [MULT_STAGES];
    logic                     r_vld_d   [MULT_STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MULT_STAGES; i++) begin
                r_vld_d[i] <= 1'b0;
            end
        end else begin
            r_vld_d[0] <= r_in_vld;
            for (int i = 1; i < MULT_STAGES; i++) begin
                r_vld_d[i] <= r_vld_d[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_pr_d[0]    <= w_pr;
        r_pi_d[0]    <= w_pi;
        r_xa_re_d[0] <= r_xa_re;
        r_xa_im_d[0] <= r_xa_im;
        r_scale_d[0] <= r_in_scale;
        r_m_d[0]     <= r_in_m;
        for (int i = 1; i < MULT_STAGES; i++) begin
            r_pr_d[i]    <= r_pr_d[i-1];
            r_pi_d[i]    <= r_pi_d[i-1];
            r_xa_re_d[i] <= r_xa_re_d[i-1];
            r_xa_im_d[i] <= r_xa_im_d[i-1];
            r_scale_d[i] <= r_scale_d[i-1];
            r_m_d[i]     <= r_m_d[i-1];
        end
    end

    // Add/sub stage; component order is ya_re, ya_im, yb_re, yb_im
    logic signed [SW-1:0] w_xa_re, w_xa_im;
    logic signed [SW-1:0] w_sum [4];
    logic signed [SW-1:0] w_scl [4];
    logic signed [SW-1:0] r_s   [4];
    logic                 r_a_vld;
    logic [MWIDTH-1:0]    r_a_m;

    assign w_xa_re = SW'(r_xa_re_d[L]);
    assign w_xa_im = SW'(r_xa_im_d[L]);

    always_comb begin
        w_sum[0] = w_xa_re + r_pr_d[L];
        w_sum[1] = w_xa_im + r_pi_d[L];
        w_sum[2] = w_xa_re - r_pr_d[L];
        w_sum[3] = w_xa_im - r_pi_d[L];
        for (int k = 0; k < 4; k++) begin
            w_scl[k] = r_scale_d[L] ? (w_sum[k] >>> 1) : w_sum[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_vld <= 1'b0;
        end else begin
            r_a_vld <= r_vld_d[L];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            r_s[k] <= w_scl[k];
        end
        r_a_m <= r_m_d[L];
    end

    // Range check and final narrowing to DWIDTH bits
    logic [3:0]        w_hit;
    logic [DWIDTH-1:0] w_fin [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_hit[k] = (r_s[k] > MAXV) || (r_s[k] < MINV);
`ifdef BUTTERFLY_PIPE_SAT_EN
            if (r_s[k] > MAXV) begin
                w_fin[k] = {1'b0, {(DWIDTH-1){1'b1}}};
            end else if (r_s[k] < MINV) begin
                w_fin[k] = {1'b1, {(DWIDTH-1){1'b0}}};
            end else begin
                w_fin[k] = r_s[k][DWIDTH-1:0];
            end
`else
            w_fin[k] = r_s[k][DWIDTH-1:0];
`endif
        end
    end

    // Output stage: results hold between valid samples; ovf set wins over clear
    logic [2*DWIDTH-1:0] r_ya, r_yb;
    logic [MWIDTH-1:0]   r_m_out;
    logic                r_y_nd;
    logic                r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y_nd  <= 1'b0;
            r_ya    <= '0;
            r_yb    <= '0;
            r_m_out <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_y_nd <= r_a_vld;
            if (r_a_vld) begin
                r_ya    <= {w_fin[0], w_fin[1]};
                r_yb    <= {w_fin[2], w_fin[3]};
                r_m_out <= r_a_m;
            end
            if (r_a_vld && (|w_hit)) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.ya    = r_ya;
    assign bus.yb    = r_yb;
    assign bus.m_out = r_m_out;
    assign bus.y_nd  = r_y_nd;
    assign bus.ovf   = r_ovf;
endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed testbench for butterfly_pipe (DWIDTH=16, TWIDTH=16, MULT_STAGES=2, latency 4).
// Honours BUTTERFLY_PIPE_SAT_EN for the expected overflowed component values.
module tb_butterfly_pipe;
    localparam int DW  = 16;
    localparam int TW  = 16;
    localparam int MW  = 3;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    butterfly_pipe_if #(.DWIDTH(DW), .TWIDTH(TW), .MWIDTH(MW)) bus ();

    butterfly_pipe #(
        .DWIDTH(DW), .TWIDTH(TW), .MWIDTH(MW), .MULT_STAGES(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [66:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cpx(input int re, input int im);
        logic [31:0] r;
        r = {re[15:0], im[15:0]};
        return r;
    endfunction

    task automatic drive(input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] w,
                         input logic sc, input logic [2:0] m);
        bus.xa    = xa;
        bus.xb    = xb;
        bus.w     = w;
        bus.scale = sc;
        bus.m_in  = m;
        bus.x_nd  = 1'b1;
    endtask

    task automatic idle();
        bus.x_nd = 1'b0;
    endtask

    // Called just after the accepting edge: y_nd must stay low for LAT-1 edges, then rise.
    task automatic expect_out(input string tag, input logic [31:0] ya, input logic [31:0] yb,
                              input logic [2:0] m);
        for (int k = 1; k < LAT; k++) begin
            tick();
            check({tag, "_early"}, 32'(bus.y_nd), 32'd0);
        end
        tick();
        check({tag, "_nd"}, 32'(bus.y_nd), 32'd1);
        check({tag, "_ya"}, bus.ya, ya);
        check({tag, "_yb"}, bus.yb, yb);
        check({tag, "_m"}, 32'(bus.m_out), 32'(m));
    endtask

    task automatic model(input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] w,
                         input logic sc, output logic [31:0] ya, output logic [31:0] yb);
        longint ar, ai, br, bi, wr, wi, pr, pi, v;
        longint s[4];
        logic [15:0] r[4];
        ar = longint'($signed(xa[31:16]));
        ai = longint'($signed(xa[15:0]));
        br = longint'($signed(xb[31:16]));
        bi = longint'($signed(xb[15:0]));
        wr = longint'($signed(w[31:16]));
        wi = longint'($signed(w[15:0]));
        pr = (br * wr - bi * wi) >>> 15;
        pi = (br * wi + bi * wr) >>> 15;
        s[0] = ar + pr;
        s[1] = ai + pi;
        s[2] = ar - pr;
        s[3] = ai - pi;
        for (int k = 0; k < 4; k++) begin
            v = sc ? (s[k] >>> 1) : s[k];
`ifdef BUTTERFLY_PIPE_SAT_EN
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
`endif
            r[k] = v[15:0];
        end
        ya = {r[0], r[1]};
        yb = {r[2], r[3]};
    endtask

    int tp_xar[8] = '{1000, -3000, 5, 0, 7000, -10000, 12345, -1};
    int tp_xai[8] = '{-500, 2000, -7, 0, -7000, 10000, -2345, 1};
    int tp_xbr[8] = '{100, 4000, 3, -1, -8000, 10000, -321, 0};
    int tp_xbi[8] = '{200, -1000, 9, -1, 6000, 10000, 4321, 0};
    int tp_wr[8]  = '{0, 16384, -32768, 1, 23170, 0, -20000, -32768};
    int tp_wi[8]  = '{-32768, 16384, 0, 0, -23170, 32767, 12000, -32768};
    logic tp_sc[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    logic [31:0] ovf_ya, neg_ya, e_ya, e_yb;
    logic [66:0] e;

    initial begin
`ifdef BUTTERFLY_PIPE_SAT_EN
        ovf_ya = cpx(32767, 0);
        neg_ya = cpx(-32768, 5);
`else
        ovf_ya = cpx(-1537, 0);
        neg_ya = cpx(1, 5);
`endif
        bus.xa = '0; bus.xb = '0; bus.w = '0; bus.scale = 1'b0;
        bus.m_in = '0; bus.x_nd = 1'b0; bus.ovf_clr = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_nd", 32'(bus.y_nd), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_ya", bus.ya, 32'd0);
        check("rst_yb", bus.yb, 32'd0);
        check("rst_m", 32'(bus.m_out), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic compute with a -1.0 imaginary twiddle, then hold while idle
        drive(cpx(1000, -500), cpx(100, 200), cpx(0, -32768), 1'b0, 3'd1);
        tick();
        idle();
        expect_out("basic", cpx(1200, -600), cpx(800, -400), 3'd1);
        check("basic_ovf", 32'(bus.ovf), 32'd0);
        tick();
        check("hold_nd", 32'(bus.y_nd), 32'd0);
        check("hold_ya", bus.ya, cpx(1200, -600));
        check("hold_m", 32'(bus.m_out), 32'd1);

        // Scaling
        drive(cpx(1000, -500), cpx(100, 200), cpx(0, -32768), 1'b1, 3'd2);
        tick();
        idle();
        expect_out("scale", cpx(600, -300), cpx(400, -200), 3'd2);

        // Positive overflow, sticky flag, explicit clear
        drive(cpx(32000, 0), cpx(32000, 0), cpx(32767, 0), 1'b0, 3'd4);
        tick();
        idle();
        expect_out("ovf", ovf_ya, cpx(1, 0), 3'd4);
        check("ovf_set", 32'(bus.ovf), 32'd1);
        repeat (100) tick();
        check("ovf_sticky", 32'(bus.ovf), 32'd1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf_clr", 32'(bus.ovf), 32'd0);

        // Negative overflow with twiddle -1.0
        drive(cpx(-32768, 5), cpx(32767, 0), cpx(-32768, 0), 1'b0, 3'd5);
        tick();
        idle();
        expect_out("novf", neg_ya, cpx(-1, 5), 3'd5);
        check("novf_set", 32'(bus.ovf), 32'd1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("novf_clr", 32'(bus.ovf), 32'd0);

        // Throughput: 8 back-to-back inputs against the reference model
        for (int t = 1; t <= 14; t++) begin
            if (t <= 8) begin
                drive(cpx(tp_xar[t-1], tp_xai[t-1]), cpx(tp_xbr[t-1], tp_xbi[t-1]),
                      cpx(tp_wr[t-1], tp_wi[t-1]), tp_sc[t-1], 3'(t-1));
                model(cpx(tp_xar[t-1], tp_xai[t-1]), cpx(tp_xbr[t-1], tp_xbi[t-1]),
                      cpx(tp_wr[t-1], tp_wi[t-1]), tp_sc[t-1], e_ya, e_yb);
                exp_q.push_back({3'(t-1), e_ya, e_yb});
            end else begin
                idle();
            end
            tick();
            check("tp_nd", 32'(bus.y_nd), 32'((t >= 5) && (t <= 12)));
            if (bus.y_nd) begin
                if (exp_q.size() == 0) begin
                    check("tp_extra", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("tp_m", 32'(bus.m_out), 32'(e[66:64]));
                    check("tp_ya", bus.ya, e[63:32]);
                    check("tp_yb", bus.yb, e[31:0]);
                end
            end
        end
        check("tp_left", 32'(exp_q.size()), 32'd0);
        check("tp_ovf", 32'(bus.ovf), 32'd0);

        // Reset with three samples in flight and one offered during reset
        for (int i = 0; i < 3; i++) begin
            drive(cpx(100 * i, 1), cpx(7, 7), cpx(16384, 0), 1'b0, 3'(i));
            tick();
        end
        drive(cpx(9, 9), cpx(9, 9), cpx(16384, 0), 1'b0, 3'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle();
        check("mid_nd", 32'(bus.y_nd), 32'd0);
        check("mid_ya", bus.ya, 32'd0);
        check("mid_yb", bus.yb, 32'd0);
        check("mid_m", 32'(bus.m_out), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("mid_flush", 32'(bus.y_nd), 32'd0);
        end
        drive(cpx(1000, -500), cpx(100, 200), cpx(0, -32768), 1'b0, 3'd6);
        tick();
        idle();
        expect_out("post", cpx(1200, -600), cpx(800, -400), 3'd6);

        // Set beats clear in the same cycle; clear alone then works
        drive(cpx(32000, 0), cpx(32000, 0), cpx(32767, 0), 1'b0, 3'd7);
        tick();
        idle();
        repeat (LAT - 1) tick();
        check("prio_pre", 32'(bus.ovf), 32'd0);
        bus.ovf_clr = 1'b1;
        tick();
        check("prio_nd", 32'(bus.y_nd), 32'd1);
        check("prio_ovf", 32'(bus.ovf), 32'd1);
        tick();
        bus.ovf_clr = 1'b0;
        check("prio_clr", 32'(bus.ovf), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
